seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits. It shares a single combinational BCD-to-7-segment decoder across NUM_DIGITS digits. Each scan slot presents one nibble to the decoder, registers the decoded pattern and drives the matching active-low anode. New display values are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new values.

---
 rtl/seg7_scan_ctrl_if.sv | 15 +
 rtl/seg7_scan_ctrl.sv | 73 +++++++
 tb/tb_seg7_scan_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: display-side bundle of the 7-segment scan controller.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    upd_ack;
    logic [3:0]              digit_bcd;
    logic [7:0]              seg_in;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an;
    modport master (output en, load, value, seg_in, input upd_ack, digit_bcd, seg_out, an);
    modport slave (input en, load, value, seg_in, output upd_ack, digit_bcd, seg_out, an);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan with frame-synchronous double-buffered updates.
// Define SEG7_LZ_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input logic             clk,
    input logic             resetn,
    seg7_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [CW-1:0]         div_cnt;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         active;
    logic [VW-1:0]         pending;
    logic                  pend_flag;
    logic                  slot_end;
    logic                  frame_end;
    logic                  commit;
    logic                  dark;
    logic [NUM_DIGITS-1:0] blank;

    assign slot_end      = div_cnt == CW'(REFRESH_DIV - 1);
    assign frame_end     = slot_end && idx == IW'(NUM_DIGITS - 1);
    assign commit        = bus.en && frame_end && pend_flag;
    assign bus.digit_bcd = active[4*idx +: 4];

`ifdef SEG7_LZ_BLANK_EN
    // Scan from the most significant digit down; blank while every nibble so far is zero.
    always_comb begin
        logic z;
        z = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            z = z && active[4*i +: 4] == 4'd0;
            blank[i] = z;
        end
    end
`else
    assign blank = '0;
`endif

    assign dark = !bus.en || div_cnt < CW'(DEAD_CYCLES) || blank[idx];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt     <= '0;
            idx         <= '0;
            active      <= '0;
            pending     <= '0;
            pend_flag   <= 1'b0;
            bus.upd_ack <= 1'b0;
            bus.an      <= '1;
            bus.seg_out <= 8'hFF;
        end else begin
            bus.upd_ack <= commit;
            if (bus.load) pending <= bus.value;
            // A load coinciding with a commit re-arms the flag for the new value.
            pend_flag <= bus.load || (pend_flag && !commit);
            if (commit) active <= pending;
            if (bus.en) begin
                div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
                if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
            end
            bus.an      <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
            bus.seg_out <= dark ? 8'hFF : bus.seg_in;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed bench, NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
// n counts clock edges since reset release; after edge n the scan position is n mod 32.
module tb_seg7_scan_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n, acks, ack_n, checks, failures;
    logic [7:0] hex_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] an_sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
`ifdef SEG7_LZ_BLANK_EN
    logic [3:0] lz_an_a [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [7:0] lz_sg_a [4] = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};
    logic [3:0] lz_an_b [4] = '{4'hE, 4'hF, 4'hF, 4'hF};
    logic [7:0] lz_sg_b [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`endif

    seg7_scan_ctrl_if #(.NUM_DIGITS(4)) ifc ();

    seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (ifc)
    );

    assign ifc.seg_in = hex_lut[ifc.digit_bcd];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (ifc.upd_ack) begin
            acks++;
            ack_n = n;
        end
    endtask

    task automatic tick_to(input int target);
        while (n < target) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        ifc.value = v;
        ifc.load = 1'b1;
        tick();
        ifc.load = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        repeat (cycles) tick();
        resetn = 1'b1;
        n = 0;
        acks = 0;
        ack_n = 0;
    endtask

    initial begin
        ifc.en = 1'b1;
        ifc.load = 1'b0;
        ifc.value = '0;
        // reset state
        do_reset(3);
        check("rst_an", ifc.an, 4'hF);
        check("rst_seg", ifc.seg_out, 8'hFF);
        check("rst_bcd", ifc.digit_bcd, 4'h0);
        check("rst_ack", ifc.upd_ack, 1'b0);
        // first update committed at the frame boundary (edge 32)
        tick();
        do_load(16'h1234);
        tick_to(32);
        check("upd1_acks", acks, 1);
        check("upd1_at", ack_n, 32);
        check("upd1_bcd", ifc.digit_bcd, 4'h4);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("slot0_an", ifc.an, i < 2 ? 4'hF : 4'hE);
            check("slot0_seg", ifc.seg_out, i < 2 ? 8'hFF : 8'h99);
        end
        // two loads in one frame: last wins, one ack
        acks = 0;
        tick_to(41);
        do_load(16'h1111);
        tick_to(49);
        do_load(16'h2222);
        tick_to(64);
        check("upd2_acks", acks, 1);
        check("upd2_at", ack_n, 64);
        for (int s = 0; s < 4; s++) begin
            tick_to(64 + 8 * s);
            check("upd2_bcd", ifc.digit_bcd, 4'h2);
            tick_to(67 + 8 * s);
            check("upd2_an", ifc.an, an_sel[s]);
            check("upd2_seg", ifc.seg_out, 8'hA4);
        end
        tick_to(96);
        check("upd2_single", acks, 1);
        // freeze in slot 1 after div_cnt=4 was consumed
        tick_to(109);
        check("pre_freeze_an", ifc.an, 4'hD);
        ifc.en = 1'b0;
        repeat (10) begin
            tick();
            check("frz_an", ifc.an, 4'hF);
            check("frz_seg", ifc.seg_out, 8'hFF);
        end
        ifc.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("resume_an", ifc.an, 4'hD);
            check("resume_seg", ifc.seg_out, 8'hA4);
        end
        tick();
        check("resume_end_an", ifc.an, 4'hF);
        // reset discards a queued update
        do_load(16'h5678);
        tick_to(n + 6);
        do_reset(2);
        check("rst2_an", ifc.an, 4'hF);
        for (int s = 0; s < 4; s++) begin
            tick_to(32 + 8 * s);
            check("rst2_bcd", ifc.digit_bcd, 4'h0);
        end
        check("rst2_acks", acks, 0);
        // load coinciding with commit: old pending committed, new one queued
        do_load(16'h4321);
        tick_to(63);
        do_load(16'h8765);
        check("coin_acks", acks, 1);
        check("coin_at", ack_n, 64);
        check("coin_bcd0", ifc.digit_bcd, 4'h1);
        tick_to(72);
        check("coin_bcd1", ifc.digit_bcd, 4'h2);
        tick_to(96);
        check("coin2_acks", acks, 2);
        check("coin2_at", ack_n, 96);
        check("coin2_bcd0", ifc.digit_bcd, 4'h5);
        tick_to(104);
        check("coin2_bcd1", ifc.digit_bcd, 4'h6);
`ifdef SEG7_LZ_BLANK_EN
        do_reset(2);
        tick();
        do_load(16'h0070);
        for (int s = 0; s < 4; s++) begin
            tick_to(35 + 8 * s);
            check("lz70_an", ifc.an, lz_an_a[s]);
            check("lz70_seg", ifc.seg_out, lz_sg_a[s]);
        end
        tick_to(64);
        do_load(16'h0000);
        for (int s = 0; s < 4; s++) begin
            tick_to(99 + 8 * s);
            check("lz00_an", ifc.an, lz_an_b[s]);
            check("lz00_seg", ifc.seg_out, lz_sg_b[s]);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
